// File: rtl/sram_tx_packet_reader.sv
// Reads length-framed packets out of the SRAM input FIFO through the controller's
// master read port and replays them as a sop/eop-marked byte stream to the SPI master.
module sram_tx_packet_reader #(
   parameter int MAX_PKT_LEN  = 64,
   parameter int HINT_TIMEOUT = 255,
   parameter int HOLDOFF      = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fifo_i_empty,
   output logic        master_read,
   input  logic        master_hint,
   input  logic [15:0] master_data_from_sram,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        tx_sop,
   output logic        tx_eop,
   output logic        busy,
   output logic        err_len,
   output logic        err_timeout,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      REQ_HDR  = 3'd1,
      CHK_HDR  = 3'd2,
      HOLD     = 3'd3,
      REQ_DATA = 3'd4,
      SEND_HI  = 3'd5,
      SEND_LO  = 3'd6
   } state_t;

   localparam logic [7:0] MAX_LEN  = 8'(MAX_PKT_LEN);
   localparam logic [7:0] TMO_LAST = 8'(HINT_TIMEOUT - 1);
   localparam logic [7:0] HOLD_LD  = 8'(HOLDOFF);

   state_t      state, state_d;
   logic [15:0] word, word_d;
   logic [7:0]  remaining, remaining_d;
   logic        first, first_d;
   logic [7:0]  holdoff, holdoff_d;
   logic [7:0]  tmo_cnt, tmo_cnt_d;
   logic        master_read_d, err_len_d, err_timeout_d;
   logic        tx_valid_d, tx_sop_d, tx_eop_d;
   logic [7:0]  tx_byte_d;
   logic        can_req;

   // tx stream: a byte moves on a cycle with tx_valid && tx_ready; while tx_valid is
   // high and not accepted, tx_byte/tx_sop/tx_eop hold and tx_valid stays up.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         word        <= '0;
         remaining   <= '0;
         first       <= 1'b0;
         holdoff     <= '0;
         tmo_cnt     <= '0;
         master_read <= 1'b0;
         err_len     <= 1'b0;
         err_timeout <= 1'b0;
         tx_valid    <= 1'b0;
         tx_sop      <= 1'b0;
         tx_eop      <= 1'b0;
         tx_byte     <= '0;
      end else begin
         state       <= state_d;
         word        <= word_d;
         remaining   <= remaining_d;
         first       <= first_d;
         holdoff     <= holdoff_d;
         tmo_cnt     <= tmo_cnt_d;
         master_read <= master_read_d;
         err_len     <= err_len_d;
         err_timeout <= err_timeout_d;
         tx_valid    <= tx_valid_d;
         tx_sop      <= tx_sop_d;
         tx_eop      <= tx_eop_d;
         tx_byte     <= tx_byte_d;
      end
   end

   always_comb begin
      state_d       = state;
      word_d        = word;
      remaining_d   = remaining;
      first_d       = first;
      holdoff_d     = (holdoff != 8'd0) ? holdoff - 8'd1 : 8'd0;
      tmo_cnt_d     = 8'd0;
      master_read_d = master_read;
      err_len_d     = 1'b0;
      err_timeout_d = 1'b0;
      can_req       = !fifo_i_empty && (holdoff == 8'd0);

      case (state)
         IDLE: begin
            if (can_req) state_d = REQ_HDR;
         end
         REQ_HDR, REQ_DATA: begin
            // Hints that arrive while no request is outstanding belong to nobody.
            if (!master_read) begin
               if (can_req) master_read_d = 1'b1;
            end else if (master_hint) begin
               master_read_d = 1'b0;
               word_d        = master_data_from_sram;
               holdoff_d     = HOLD_LD;
               state_d       = (state == REQ_HDR) ? CHK_HDR : SEND_HI;
            end else if (tmo_cnt == TMO_LAST) begin
               master_read_d = 1'b0;
               err_timeout_d = 1'b1;
               state_d       = IDLE;
            end else begin
               tmo_cnt_d = (tmo_cnt == 8'hFF) ? tmo_cnt : tmo_cnt + 8'd1;
            end
         end
         CHK_HDR: begin
            holdoff_d = HOLD_LD;
            if (word[7:0] == 8'd0 || word[7:0] > MAX_LEN) begin
               err_len_d = 1'b1;
               state_d   = IDLE;
            end else begin
               remaining_d = word[7:0];
               first_d     = 1'b1;
               state_d     = REQ_DATA;
            end
         end
         SEND_HI: begin
            if (tx_valid && tx_ready) begin
               remaining_d = remaining - 8'd1;
               first_d     = 1'b0;
               state_d     = (remaining == 8'd1) ? IDLE : SEND_LO;
            end
         end
         SEND_LO: begin
            if (tx_valid && tx_ready) begin
               remaining_d = remaining - 8'd1;
               state_d     = (remaining == 8'd1) ? IDLE : REQ_DATA;
            end
         end
         HOLD: state_d = REQ_DATA;
         default: state_d = IDLE;
      endcase

      // Byte outputs are a registered image of the state being entered.
      tx_valid_d = (state_d == SEND_HI) || (state_d == SEND_LO);
      tx_sop_d   = (state_d == SEND_HI) && first_d;
      tx_eop_d   = tx_valid_d && (remaining_d == 8'd1);
      if (state_d == SEND_HI)      tx_byte_d = word_d[15:8];
      else if (state_d == SEND_LO) tx_byte_d = word_d[7:0];
      else                         tx_byte_d = 8'd0;
   end

   assign busy      = (state != IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_sram_tx_packet_reader.sv
// Bench for sram_tx_packet_reader: a latency model of the SRAM controller feeds words,
// a monitor logs accepted bytes, directed vectors plus hand sequences check the stream.
module tb_sram_tx_packet_reader;

   localparam int LAT = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_i_empty;
   logic        master_read;
   logic        master_hint;
   logic [15:0] master_data_from_sram;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx_sop;
   logic        tx_eop;
   logic        busy;
   logic        err_len;
   logic        err_timeout;
   logic [2:0]  state_dbg;

   sram_tx_packet_reader #(.MAX_PKT_LEN(64), .HINT_TIMEOUT(255), .HOLDOFF(2)) dut (
      .clk(clk), .rst(rst), .fifo_i_empty(fifo_i_empty), .master_read(master_read),
      .master_hint(master_hint), .master_data_from_sram(master_data_from_sram),
      .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_sop(tx_sop),
      .tx_eop(tx_eop), .busy(busy), .err_len(err_len), .err_timeout(err_timeout),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   logic [15:0] mem_q[$];
   logic [9:0]  got_q[$];
   logic [9:0]  exp_q[$];
   int  errors = 0;
   int  checks = 0;
   int  n_req = 0, n_err_len = 0, n_err_tmo = 0, n_valid = 0;
   logic mr_prev = 1'b0;
   logic ctrl_en = 1'b1;
   int  lat_cnt = 0;

   // SRAM controller model: hint LAT cycles into a request, popping the FIFO.
   initial begin
      master_hint = 1'b0;
      master_data_from_sram = '0;
      fifo_i_empty = 1'b1;
      forever begin
         @(negedge clk);
         if (ctrl_en) begin
            if (master_hint) begin
               master_hint = 1'b0;
               lat_cnt = 0;
            end else if (master_read) begin
               if (lat_cnt == LAT - 1) begin
                  master_hint = 1'b1;
                  master_data_from_sram = (mem_q.size() != 0) ? mem_q.pop_front() : 16'h0;
                  lat_cnt = 0;
               end else lat_cnt++;
            end else lat_cnt = 0;
         end else lat_cnt = 0;
         fifo_i_empty = (mem_q.size() == 0);
      end
   end

   // Monitor: samples one time unit after the drive edge, well away from posedge.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            if (tx_valid && tx_ready) got_q.push_back({tx_sop, tx_eop, tx_byte});
            if (tx_valid) n_valid++;
            if (err_len) n_err_len++;
            if (err_timeout) n_err_tmo++;
            if (master_read && !mr_prev) n_req++;
         end
         mr_prev = master_read;
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic clear_stats();
      got_q.delete();
      exp_q.delete();
      n_req = 0; n_err_len = 0; n_err_tmo = 0; n_valid = 0;
   endtask

   task automatic wait_idle(input string name, input int max_cycles);
      int k;
      for (k = 0; k < max_cycles; k++) begin
         step();
         if (mem_q.size() == 0 && fifo_i_empty && !busy && !master_read) break;
      end
      if (k == max_cycles) chk({name, "_idle_timeout"}, 32'(k), 32'(max_cycles - 1));
      repeat (4) step();
   endtask

   task automatic cmp_stream(input string name);
      chk({name, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   typedef struct {
      string       name;
      int          n_words;
      logic [15:0] words [4];
      int          n_bytes;
      logic [7:0]  bytes [4];
      int          exp_req;
      int          exp_err_len;
   } vec_t;

   vec_t vecs [5];

   initial begin
      vecs[0] = '{"len4",   3, '{16'h0004, 16'hA1B2, 16'hC3D4, 16'h0}, 4, '{8'hA1, 8'hB2, 8'hC3, 8'hD4}, 3, 0};
      vecs[1] = '{"len3",   3, '{16'h0003, 16'h1122, 16'h3300, 16'h0}, 3, '{8'h11, 8'h22, 8'h33, 8'h0}, 3, 0};
      vecs[2] = '{"badlen", 2, '{16'h0000, 16'h0041, 16'h0, 16'h0},    0, '{8'h0, 8'h0, 8'h0, 8'h0},     2, 2};
      vecs[3] = '{"len1",   2, '{16'h0001, 16'h5A77, 16'h0, 16'h0},    1, '{8'h5A, 8'h0, 8'h0, 8'h0},    2, 0};
      vecs[4] = '{"rsvd",   2, '{16'h0102, 16'h9988, 16'h0, 16'h0},    2, '{8'h99, 8'h88, 8'h0, 8'h0},   2, 0};

      // Reset
      rst = 1'b1;
      tx_ready = 1'b1;
      repeat (3) step();
      chk("rst_outputs", {master_read, tx_valid, tx_sop, tx_eop, busy, err_len, err_timeout, tx_byte}, 32'h0);
      rst = 1'b0;
      step();
      chk("rst_state", 32'(state_dbg), 32'h0);

      // Table-driven packets
      for (int v = 0; v < 5; v++) begin
         clear_stats();
         for (int w = 0; w < vecs[v].n_words; w++) mem_q.push_back(vecs[v].words[w]);
         for (int b = 0; b < vecs[v].n_bytes; b++)
            exp_q.push_back({(b == 0), (b == vecs[v].n_bytes - 1), vecs[v].bytes[b]});
         wait_idle(vecs[v].name, 500);
         cmp_stream(vecs[v].name);
         chk({vecs[v].name, "_reqs"}, 32'(n_req), 32'(vecs[v].exp_req));
         chk({vecs[v].name, "_errlen"}, 32'(n_err_len), 32'(vecs[v].exp_err_len));
         chk({vecs[v].name, "_busy"}, 32'(busy), 32'h0);
         if (vecs[v].n_bytes == 0) chk({vecs[v].name, "_novalid"}, 32'(n_valid), 32'h0);
      end

      // Largest legal packet: 64 bytes
      clear_stats();
      mem_q.push_back(16'h0040);
      for (int i = 0; i < 32; i++) mem_q.push_back({8'(2 * i), 8'(2 * i + 1)});
      for (int i = 0; i < 64; i++) exp_q.push_back({(i == 0), (i == 63), 8'(i)});
      wait_idle("max64", 2000);
      cmp_stream("max64");
      chk("max64_reqs", 32'(n_req), 32'd33);
      chk("max64_errlen", 32'(n_err_len), 32'h0);

      // Backpressure on the first byte
      begin
         int k;
         int stable;
         clear_stats();
         tx_ready = 1'b0;
         mem_q.push_back(16'h0002);
         mem_q.push_back(16'hBEEF);
         for (k = 0; k < 300 && !tx_valid; k++) step();
         chk("stall_valid_seen", 32'(tx_valid), 32'h1);
         stable = 0;
         for (int c = 0; c < 6; c++) begin
            if (tx_valid && tx_byte == 8'hBE && tx_sop && !tx_eop) stable++;
            if (c == 5) tx_ready = 1'b1;
            step();
         end
         chk("stall_stable_cycles", 32'(stable), 32'd6);
         exp_q.push_back({1'b1, 1'b0, 8'hBE});
         exp_q.push_back({1'b0, 1'b1, 8'hEF});
         wait_idle("stall", 300);
         cmp_stream("stall");
      end

      // Hint withheld: request must time out after 255 cycles
      begin
         int k;
         int hi;
         clear_stats();
         ctrl_en = 1'b0;
         mem_q.push_back(16'h0002);
         for (k = 0; k < 50 && !master_read; k++) step();
         chk("tmo_read_seen", 32'(master_read), 32'h1);
         hi = 0;
         while (master_read && hi < 400) begin
            hi++;
            if (hi == 250) mem_q.delete();
            step();
         end
         chk("tmo_read_cycles", 32'(hi), 32'd255);
         repeat (3) step();
         chk("tmo_err_pulses", 32'(n_err_tmo), 32'h1);
         chk("tmo_idle", 32'(state_dbg), 32'h0);
         master_data_from_sram = 16'h0004;
         master_hint = 1'b1;
         step();
         master_hint = 1'b0;
         repeat (6) step();
         chk("late_hint_busy", 32'(busy), 32'h0);
         chk("late_hint_reqs", 32'(n_req), 32'h1);
         chk("late_hint_novalid", 32'(n_valid), 32'h0);
         ctrl_en = 1'b1;
      end

      // Reset in the middle of a 6-byte packet
      begin
         int k;
         clear_stats();
         mem_q.push_back(16'h0006);
         mem_q.push_back(16'h0102);
         mem_q.push_back(16'h0304);
         mem_q.push_back(16'h0506);
         for (k = 0; k < 300 && !(tx_valid && tx_byte == 8'h02); k++) step();
         chk("midrst_in_send_lo", 32'(state_dbg), 32'd6);
         rst = 1'b1;
         mem_q.delete();
         step();
         chk("midrst_outputs", {master_read, tx_valid, tx_sop, tx_eop, busy, err_len, err_timeout, tx_byte}, 32'h0);
         rst = 1'b0;
         step();
         clear_stats();
         mem_q.push_back(16'h0002);
         mem_q.push_back(16'hCAFE);
         exp_q.push_back({1'b1, 1'b0, 8'hCA});
         exp_q.push_back({1'b0, 1'b1, 8'hFE});
         wait_idle("after_rst", 300);
         cmp_stream("after_rst");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram_tx_packet_reader.md
Name: sram_tx_packet_reader

Overview:
- Drains framed packets from the SRAM input FIFO region through the SRAM controller's master read port.
- Serialises each packet into a byte stream with sop/eop marks for the SPI master that loads the Si4463 TX FIFO.
- Sits between the SRAM controller (master_read/master_hint side) and the radio SPI master.
- Packet format in SRAM: one header word (bits [7:0] = payload length in bytes, bits [15:8] reserved), followed by ceil(len/2) payload words, high byte first.

Parameters:
- MAX_PKT_LEN, 64: largest legal payload length in bytes; header len of 0 or > MAX_PKT_LEN is an error.
- HINT_TIMEOUT, 255: cycles to wait for master_hint before abandoning a read.
- HOLDOFF, 2: idle cycles after each hint before a new read request (covers the one-cycle lag of the FIFO empty flag).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- fifo_i_empty  in  1  input FIFO empty flag from SRAM controller
- master_read  out  1  read request to SRAM controller, level
- master_hint  in  1  one-cycle completion pulse from SRAM controller
- master_data_from_sram  in  16  read data, valid in the master_hint cycle
- tx_byte  out  8  byte to SPI master
- tx_valid  out  1  tx_byte valid
- tx_ready  in  1  SPI master accepts byte
- tx_sop  out  1  first payload byte of packet, qualified by tx_valid
- tx_eop  out  1  last payload byte of packet, qualified by tx_valid
- busy  out  1  packet in progress (not IDLE)
- err_len  out  1  one-cycle pulse: illegal header dropped
- err_timeout  out  1  one-cycle pulse: hint timeout

Behaviour:
- Reset: synchronous, active-high. All outputs are 0; tx_byte = 0; state = IDLE; counters = 0.
- States: IDLE, REQ_HDR, CHK_HDR, HOLD, REQ_DATA, SEND_HI, SEND_LO.
- Read handshake:
  - master_read is a registered output, raised in a REQ state only when fifo_i_empty = 0 and the holdoff counter = 0.
  - master_read is held until master_hint is sampled high, then cleared on the next edge.
  - On the hint cycle, master_data_from_sram is captured into a 16-bit word register.
  - A hint while master_read = 0 is ignored.
- IDLE -> REQ_HDR when fifo_i_empty = 0 and holdoff = 0.
- REQ_HDR -> CHK_HDR on hint; the header is captured.
- CHK_HDR:
  - len = header[7:0].
  - If len = 0 or len > MAX_PKT_LEN: pulse err_len, load holdoff, go to IDLE. Only the header word is consumed.
  - Otherwise: remaining = len, first = 1, load holdoff, go to REQ_DATA.
- REQ_DATA:
  - Waits for holdoff = 0 and fifo_i_empty = 0, then requests one word.
  - On hint: load holdoff, go to SEND_HI.
  - If the FIFO stays empty, it waits indefinitely with master_read = 0 (the writer is still filling).
- SEND_HI:
  - tx_byte = word[15:8], tx_valid = 1, tx_sop = first, tx_eop = (remaining = 1).
  - On tx_valid & tx_ready: remaining -= 1, first = 0.
  - Next state: IDLE if remaining was 1, else SEND_LO.
- SEND_LO:
  - tx_byte = word[7:0], tx_eop = (remaining = 1).
  - On accept: remaining -= 1.
  - Next state: IDLE if remaining was 1, else REQ_DATA.
- Odd len: the low byte of the last word is discarded.
- Byte stream rules:
  - tx_byte/tx_valid/tx_sop/tx_eop are registered.
  - They are stable while tx_valid = 1 and tx_ready = 0.
  - tx_valid never drops without acceptance.
- Throughput: at most one byte per cycle within a word. Each word costs at least 1 + controller latency (~6 cycles) + HOLDOFF cycles.
- Holdoff counter: loaded with HOLDOFF on every hint; decrements to 0 in every state.
- Timeout:
  - A counter runs while master_read = 1; it clears when the request is taken or dropped.
  - On reaching HINT_TIMEOUT: drop master_read, pulse err_timeout, return to IDLE and abandon the packet.
  - Partial packets already sent are not terminated with eop; downstream flushes on err_timeout.
- Reset mid-operation: immediate return to IDLE. An in-flight controller read may still complete; its hint is ignored because master_read = 0.
- busy = (state != IDLE).
- Widths:
  - remaining: 8 bits, unsigned, never underflows (len >= 1 is guaranteed at load).
  - Timeout counter: 8 bits, saturates.

Test Plan:
- Header 0x0004, words 0xA1B2, 0xC3D4, tx_ready = 1 -> bytes A1(sop), B2, C3, D4(eop); exactly 3 master_read requests; busy returns 0.
- Header 0x0003, word 0x1122, 0x3300 -> bytes 11(sop), 22, 33(eop); 0x00 never emitted; next header read starts from IDLE.
- Header 0x0000, then header 0x0041 with MAX_PKT_LEN = 64 -> err_len pulses twice (one cycle each); no tx_valid; one master_read per header.
- Header 0x0002, data 0xBEEF, tx_ready low for 5 cycles on first byte -> BE held stable with tx_valid = 1 for 6 cycles, then EF(eop).
- master_read asserted, master_hint withheld for 255 cycles -> master_read drops, err_timeout pulses for 1 cycle, state IDLE; a late hint is ignored.
- rst asserted during SEND_LO of a 6-byte packet -> next cycle: all outputs 0, busy = 0; the following packet begins with sop.
